// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the stack_arbiter controller and its testbench.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int POP_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(POP_LAT_MAX);

  // A request is rejected before it reaches the stack when it cannot complete.
  function automatic logic op_illegal(input logic op, input logic empty, input logic full);
    return (op == OP_PUSH) ? full : empty;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic r_ptr;

  always_comb begin
    // NOTE: gnt gets a default before the case so no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!Rst) begin
      r_ptr <= 1'b0;
    end else if (grant_en && |gnt) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one push-down stack between two clients: round-robin grant, legality
// screening, one-cycle En pulse, and registered acknowledge with pop data.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int POP_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stk_en,
  output logic              stk_pushpop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  input  logic              stk_empty,
  input  logic              stk_full,
  output logic              busy
);

  state_t             r_state, w_state_nxt;
  logic               r_win, w_win_nxt;
  logic               r_op, w_op_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic               r_stk_en, w_stk_en_nxt;
  logic               r_stk_pushpop, w_stk_pushpop_nxt;
  logic [DATA_W-1:0]  r_stk_wdata, w_stk_wdata_nxt;
  logic [1:0]         r_ack, w_ack_nxt;
  logic [1:0]         r_err, w_err_nxt;
  logic [DATA_W-1:0]  r_rdata0, w_rdata0_nxt;
  logic [DATA_W-1:0]  r_rdata1, w_rdata1_nxt;
  logic               r_busy;

  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_grant_en;
  logic               w_win_id;
  logic               w_win_op;
  logic [DATA_W-1:0]  w_win_wdata;

  assign w_req       = {req1, req0};
  assign w_grant_en  = (r_state == IDLE) && (|w_req);
  assign w_win_id    = w_gnt[1];
  assign w_win_op    = w_win_id ? op1 : op0;
  assign w_win_wdata = w_win_id ? wdata1 : wdata0;

  rr_arb2 u_arb (
    .Clk      (Clk),
    .Rst      (Rst),
    .req      (w_req),
    .grant_en (w_grant_en),
    .gnt      (w_gnt)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_win_nxt         = r_win;
    w_op_nxt          = r_op;
    w_cnt_nxt         = r_cnt;
    w_stk_en_nxt      = 1'b0;
    w_stk_pushpop_nxt = 1'b0;
    w_stk_wdata_nxt   = '0;
    w_ack_nxt         = 2'b00;
    w_err_nxt         = 2'b00;
    w_rdata0_nxt      = r_rdata0;
    w_rdata1_nxt      = r_rdata1;

    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_win_nxt = w_win_id;
          w_op_nxt  = w_win_op;
          if (op_illegal(w_win_op, stk_empty, stk_full)) begin
            w_state_nxt         = RESP;
            w_ack_nxt[w_win_id] = 1'b1;
            w_err_nxt[w_win_id] = 1'b1;
            if (w_win_id) w_rdata1_nxt = '0;
            else          w_rdata0_nxt = '0;
          end else begin
            w_state_nxt       = ISSUE;
            w_stk_en_nxt      = 1'b1;
            w_stk_pushpop_nxt = w_win_op;
            w_stk_wdata_nxt   = w_win_wdata;
          end
        end
      end
      ISSUE: begin
        if (r_op == OP_POP) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt      = RESP;
          w_ack_nxt[r_win] = 1'b1;
          if (r_win) w_rdata1_nxt = '0;
          else       w_rdata0_nxt = '0;
        end
      end
      WAIT: begin
        // Stack data is taken on the last of POP_LAT cycles after the En pulse.
        if (r_cnt == CNT_W'(POP_LAT - 1)) begin
          w_state_nxt      = RESP;
          w_ack_nxt[r_win] = 1'b1;
          if (r_win) w_rdata1_nxt = stk_rdata;
          else       w_rdata0_nxt = stk_rdata;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= IDLE;
      r_win         <= 1'b0;
      r_op          <= OP_PUSH;
      r_cnt         <= '0;
      r_stk_en      <= 1'b0;
      r_stk_pushpop <= 1'b0;
      r_stk_wdata   <= '0;
      r_ack         <= 2'b00;
      r_err         <= 2'b00;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_win         <= w_win_nxt;
      r_op          <= w_op_nxt;
      r_cnt         <= w_cnt_nxt;
      r_stk_en      <= w_stk_en_nxt;
      r_stk_pushpop <= w_stk_pushpop_nxt;
      r_stk_wdata   <= w_stk_wdata_nxt;
      r_ack         <= w_ack_nxt;
      r_err         <= w_err_nxt;
      r_rdata0      <= w_rdata0_nxt;
      r_rdata1      <= w_rdata1_nxt;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  assign stk_en      = r_stk_en;
  assign stk_pushpop = r_stk_pushpop;
  assign stk_wdata   = r_stk_wdata;
  assign ack0        = r_ack[0];
  assign ack1        = r_ack[1];
  assign err0        = r_err[0];
  assign err1        = r_err[1];
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign busy        = r_busy;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter driving a small behavioural push-down stack.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int DATA_W  = 8;
  localparam int POP_LAT = 1;
  localparam int DEPTH   = 4;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              ack0, ack1, err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              stk_en, stk_pushpop, busy;
  logic [DATA_W-1:0] stk_wdata;
  logic [DATA_W-1:0] stk_rdata;
  logic              stk_empty, stk_full;

  int n_tests = 0;
  int n_fail  = 0;
  int en_total = 0;

  always #5 Clk = ~Clk;

  stack_arbiter #(.DATA_W(DATA_W), .POP_LAT(POP_LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .stk_en(stk_en), .stk_pushpop(stk_pushpop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_empty(stk_empty), .stk_full(stk_full),
    .busy(busy)
  );

  // Behavioural stack: data_o valid one cycle after a pop En pulse.
  logic [DATA_W-1:0] mem [DEPTH];
  int sp;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sp        <= 0;
      stk_rdata <= '0;
    end else if (stk_en) begin
      if (stk_pushpop == OP_PUSH) begin
        if (sp < DEPTH) begin
          mem[sp] <= stk_wdata;
          sp      <= sp + 1;
        end
      end else if (sp > 0) begin
        stk_rdata <= mem[sp-1];
        sp        <= sp - 1;
      end
    end
  end
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DEPTH);

  always @(posedge Clk) if (stk_en) en_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int who, input logic r, input logic op, input logic [DATA_W-1:0] wd);
    if (who == 0) begin req0 = r; op0 = op; wdata0 = wd; end
    else          begin req1 = r; op1 = op; wdata1 = wd; end
  endtask

  // One transaction from an idle controller; called just after a falling edge.
  task automatic txn(input int who, input logic op, input logic [DATA_W-1:0] wd,
                     input int exp_lat, input logic exp_err,
                     input logic [DATA_W-1:0] exp_rd, input string tag);
    int   cyc = 0;
    int   en_cnt = 0;
    logic got = 1'b0;
    logic other = 1'b0;
    logic e_seen;
    logic [DATA_W-1:0] rd_seen;
    e_seen = 1'b0;
    rd_seen = '0;
    drive(who, 1'b1, op, wd);
    while (!got && cyc < 20) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) check({tag, ".busy"}, busy, 1'b1);
      if (stk_en) begin
        en_cnt++;
        check({tag, ".pushpop"}, stk_pushpop, op);
        if (op == OP_PUSH) check({tag, ".wdata"}, stk_wdata, wd);
      end
      if ((who == 0) ? ack1 : ack0) other = 1'b1;
      if ((who == 0) ? ack0 : ack1) begin
        got     = 1'b1;
        e_seen  = (who == 0) ? err0 : err1;
        rd_seen = (who == 0) ? rdata0 : rdata1;
      end
    end
    drive(who, 1'b0, op, wd);
    check({tag, ".ack_seen"}, got, 1'b1);
    check({tag, ".latency"}, cyc, exp_lat);
    check({tag, ".err"}, e_seen, exp_err);
    check({tag, ".rdata"}, rd_seen, exp_rd);
    check({tag, ".en_pulses"}, en_cnt, exp_err ? 0 : 1);
    check({tag, ".other_ack"}, other, 1'b0);
    @(negedge Clk);
    check({tag, ".ack_pulse"}, {ack1, ack0}, 2'b00);
  endtask

  task automatic reset_dut();
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
  endtask

  int seq [20];
  int n0, n1, n_err, alt_bad, cyc, first_id, second_id, t_first, t_second;
  logic ack_in_rst;

  initial begin
    // Reset default
    repeat (3) @(negedge Clk);
    check("rst.outputs_low",
          {ack0, ack1, err0, err1, rdata0, rdata1, stk_en, stk_pushpop, stk_wdata, busy}, 32'h0);
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    check("idle.outputs_low",
          {ack0, ack1, err0, err1, rdata0, rdata1, stk_en, stk_pushpop, stk_wdata, busy}, 32'h0);
    check("idle.no_en", en_total, 0);

    // Push then pop
    txn(0, OP_PUSH, 8'h5A, 2, 1'b0, 8'h00, "push0_5a");
    txn(0, OP_POP,  8'h00, 2 + POP_LAT, 1'b0, 8'h5A, "pop0_5a");

    // Simultaneous pushes with a fresh pointer: requester 0 first
    reset_dut();
    drive(0, 1'b1, OP_PUSH, 8'h11);
    drive(1, 1'b1, OP_PUSH, 8'h22);
    first_id = -1; second_id = -1; t_first = 0; t_second = 0; cyc = 0;
    while (second_id < 0 && cyc < 30) begin
      @(negedge Clk);
      cyc++;
      if (ack0 || ack1) begin
        if (first_id < 0) begin first_id = ack1 ? 1 : 0; t_first = cyc; end
        else              begin second_id = ack1 ? 1 : 0; t_second = cyc; end
        check("simul.err", {err1, err0}, 2'b00);
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge Clk);
    check("simul.first", first_id, 0);
    check("simul.second", second_id, 1);
    check("simul.first_lat", t_first, 2);
    check("simul.spacing", t_second - t_first, 3);
    txn(1, OP_POP, 8'h00, 2 + POP_LAT, 1'b0, 8'h22, "pop1_22");
    txn(1, OP_POP, 8'h00, 2 + POP_LAT, 1'b0, 8'h11, "pop1_11");

    // Error cases
    txn(0, OP_POP, 8'h00, 1, 1'b1, 8'h00, "pop_empty");
    for (int i = 0; i < DEPTH; i++)
      txn(0, OP_PUSH, 8'hA0 + DATA_W'(i), 2, 1'b0, 8'h00, "fill");
    check("fill.full", stk_full, 1'b1);
    txn(1, OP_PUSH, 8'hFF, 1, 1'b1, 8'h00, "push_full");
    check("push_full.depth", sp, DEPTH);
    txn(0, OP_POP, 8'h00, 2 + POP_LAT, 1'b0, 8'hA3, "pop_a3");
    txn(1, OP_POP, 8'h00, 2 + POP_LAT, 1'b0, 8'hA2, "pop_a2");
    check("rdata0.hold", rdata0, 8'hA3);
    txn(0, OP_POP, 8'h00, 2 + POP_LAT, 1'b0, 8'hA1, "pop_a1");
    txn(0, OP_POP, 8'h00, 2 + POP_LAT, 1'b0, 8'hA0, "pop_a0");

    // Fairness: last grant went to 0, so requester 1 (pop on empty) leads
    drive(0, 1'b1, OP_PUSH, 8'h77);
    drive(1, 1'b1, OP_POP, 8'h00);
    n0 = 0; n1 = 0; n_err = 0; cyc = 0;
    while ((n0 + n1) < 20 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (ack0 || ack1) begin
        seq[n0 + n1] = ack1 ? 1 : 0;
        if (ack0 && err0) n_err++;
        if (ack1 && err1) n_err++;
        if (ack1 && !err1) check("fair.pop_data", rdata1, 8'h77);
        if (ack1) n1++; else n0++;
        if ((n0 + n1) == 20) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge Clk);
    alt_bad = 0;
    for (int i = 1; i < 20; i++) if (seq[i] == seq[i-1]) alt_bad++;
    check("fair.first", seq[0], 1);
    check("fair.alternation", alt_bad, 0);
    check("fair.count0", n0, 10);
    check("fair.count1", n1, 10);
    check("fair.errors", n_err, 1);

    // Reset mid-pop while in WAIT
    drive(0, 1'b1, OP_POP, 8'h00);
    @(negedge Clk);
    check("rstpop.en_issue", stk_en, 1'b1);
    @(negedge Clk);
    check("rstpop.busy_wait", busy, 1'b1);
    check("rstpop.no_ack_yet", ack0, 1'b0);
    Rst = 1'b0;
    #1;
    check("rstpop.async_drop", {stk_en, ack0, ack1, busy}, 4'b0000);
    req0 = 1'b0;
    ack_in_rst = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      if (ack0 || ack1 || stk_en) ack_in_rst = 1'b1;
    end
    Rst = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      if (ack0 || ack1) ack_in_rst = 1'b1;
    end
    check("rstpop.no_ack", ack_in_rst, 1'b0);

    // Reset during ISSUE drops the En pulse immediately
    drive(1, 1'b1, OP_PUSH, 8'h42);
    @(negedge Clk);
    check("rstissue.en_high", stk_en, 1'b1);
    Rst = 1'b0;
    #1;
    check("rstissue.en_drop", stk_en, 1'b0);
    req1 = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    txn(0, OP_PUSH, 8'h3C, 2, 1'b0, 8'h00, "push_after_rst");
    txn(0, OP_POP, 8'h00, 2 + POP_LAT, 1'b0, 8'h3C, "pop_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
